peripheral_mem: RTL and testbench
=================================

PERIPHERAL_MEM -- requirements
Module: peripheral_mem

Interface
REQ-001 Parameter RAM_WORDS, default 256, SHALL set the data RAM depth in 32-bit words; the RAM occupies byte addresses 0 to 4*RAM_WORDS-1.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 MEM_ALUOut  in  32  SHALL be the byte address from the EX/MEM register; bits [1:0] ignored.
REQ-005 MEM_WriteData  in  32  SHALL be the store data.
REQ-006 MEM_MemRead  in  1  SHALL be the load strobe.
REQ-007 MEM_MemWrite  in  1  SHALL be the store strobe.
REQ-008 switch  in  8  SHALL be the board switch inputs.
REQ-009 MEM_ReadData  out  32  SHALL be the load data feeding the MEM/WB register.
REQ-010 led  out  8  SHALL be the LED register.
REQ-011 digi  out  12  SHALL be the 7-segment drive register.
REQ-012 irqout  out  1  SHALL be the timer interrupt request to the control unit.

Function
REQ-013 The address map SHALL be: RAM 0x0-(4*RAM_WORDS-1); TH 0x40000000 RW; TL 0x40000004 RW; TCON[2:0] 0x40000008 RW; led 0x4000000C RW; switch 0x40000010 RO; digi 0x40000014 RW; systick 0x40000018 RO.
REQ-014 Reads SHALL be combinational with zero-cycle latency: MEM_ReadData valid in the same cycle MEM_MemRead=1.
REQ-015 MEM_ReadData SHALL be 0 when MEM_MemRead=0 or the address is unmapped.
REQ-016 Narrow registers SHALL read zero-extended (TCON to 3 bits, led/switch to 8 bits, digi to 12 bits).
REQ-017 Writes SHALL commit on the rising edge when MEM_MemWrite=1; writes to unmapped or RO addresses SHALL be ignored.
REQ-018 A read and write to the same address in one cycle SHALL return the pre-write value.
REQ-019 If MEM_MemRead and MEM_MemWrite are both 1, both SHALL be serviced per REQ-018.
REQ-020 TCON bit0 SHALL be the timer enable, bit1 the interrupt enable, and bit2 the sticky interrupt status.
REQ-021 When TCON[0]=1 and TL != 0xFFFFFFFF, TL SHALL increment by 1 each cycle.
REQ-022 When TCON[0]=1 and TL == 0xFFFFFFFF, TL SHALL reload TH next cycle (overflow event), and TCON[2] SHALL set if TCON[1]=1.
REQ-023 When TCON[0]=0, TL SHALL hold.
REQ-024 A CPU write to TL SHALL take priority over increment or reload in the same cycle.
REQ-025 A CPU write to TCON SHALL load bits [1:0] from MEM_WriteData[1:0], and TCON[2] SHALL become MEM_WriteData[2] OR (overflow event AND current TCON[1]), so an interrupt is never lost to a simultaneous clear.
REQ-026 irqout SHALL equal TCON[1] AND TCON[2], registered with no extra delay beyond TCON.
REQ-027 systick SHALL increment every cycle, wrap from 0xFFFFFFFF to 0, and ignore writes.
REQ-028 The switch value SHALL be read directly from the input, unregistered.

Reset
REQ-029 On reset=1 at a clock edge, TH, TL, TCON, led, digi and systick SHALL become 0, and irqout SHALL be 0 from the following cycle.
REQ-030 Reset SHALL override any simultaneous write or timer event.
REQ-031 RAM contents SHALL NOT be reset; benches SHALL NOT rely on RAM content after reset.

Verification
REQ-032 RAM write 0x12345678 to 0x10, then read 0x10 -> 0x12345678; same-cycle read+write of 0xAAAA5555 -> old 0x12345678.
REQ-033 TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 -> TL reads 0xFFFFFFFF after 1 cycle, 0xFFFFFFF0 after 2 cycles, TCON=7 and irqout=1.
REQ-034 Write TCON=3 in the overflow cycle -> TCON[2] stays 1, irqout stays 1; a later write TCON=3 with no overflow -> irqout=0.
REQ-035 Write TL=5 while running, coincident with increment -> TL reads 5 the next cycle, 6 one cycle after.
REQ-036 switch=0xA5, read 0x40000010 -> 0x000000A5; write 0x40000010 -> no effect; read 0x50000000 -> 0.
REQ-037 Assert reset mid-count with led=0xFF -> next cycle led=0, TL=0, TCON=0, systick=0, irqout=0.

Source files
------------

// File: rtl/peripheral_mem.sv
// Data-memory stage of the pipeline: word RAM plus memory-mapped timer,
// LED, switch, 7-segment and free-running systick registers.
module peripheral_mem #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_WriteData,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [7:0]  switch,
  output logic [31:0] MEM_ReadData,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [29:0] TH_W      = 30'h1000_0000;
  localparam logic [29:0] TL_W      = 30'h1000_0001;
  localparam logic [29:0] TCON_W    = 30'h1000_0002;
  localparam logic [29:0] LED_W     = 30'h1000_0003;
  localparam logic [29:0] SWITCH_W  = 30'h1000_0004;
  localparam logic [29:0] DIGI_W    = 30'h1000_0005;
  localparam logic [29:0] SYSTICK_W = 30'h1000_0006;

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  logic [29:0]   word;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;

  assign word    = MEM_ALUOut[31:2];
  assign ram_hit = (MEM_ALUOut < RAM_BYTES);
  assign ram_idx = MEM_ALUOut[AW+1:2];

  logic wr_ram, wr_th, wr_tl, wr_tcon, wr_led, wr_digi;

  assign wr_ram  = MEM_MemWrite && ram_hit;
  assign wr_th   = MEM_MemWrite && (word == TH_W);
  assign wr_tl   = MEM_MemWrite && (word == TL_W);
  assign wr_tcon = MEM_MemWrite && (word == TCON_W);
  assign wr_led  = MEM_MemWrite && (word == LED_W);
  assign wr_digi = MEM_MemWrite && (word == DIGI_W);

  // Timer next-state: a CPU write to TL beats increment/reload, and an
  // overflow with interrupts enabled always survives a concurrent TCON write.
  logic        overflow;
  logic        irq_set;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;

  assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign irq_set  = overflow && tcon[1];

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    tl_next = tl;
    if (wr_tl) begin
      tl_next = MEM_WriteData;
    end else if (tcon[0]) begin
      tl_next = overflow ? th : tl + 32'd1;
    end
  end

  always_comb begin
    tcon_next = tcon;
    if (wr_tcon) begin
      tcon_next = {MEM_WriteData[2] | irq_set, MEM_WriteData[1:0]};
    end else if (irq_set) begin
      tcon_next[2] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
      irqout  <= 1'b0;
    end else begin
      systick <= systick + 32'd1;
      tl      <= tl_next;
      tcon    <= tcon_next;
      irqout  <= tcon_next[1] & tcon_next[2];
      if (wr_th)   th   <= MEM_WriteData;
      if (wr_led)  led  <= MEM_WriteData[7:0];
      if (wr_digi) digi <= MEM_WriteData[11:0];
    end
  end

  // NOTE: the RAM array is deliberately left out of reset; resetting a
  // memory would force it into flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= MEM_WriteData;
    end
  end

  // Reads are purely combinational, so a same-cycle write is not yet visible.
  always_comb begin
    MEM_ReadData = '0;
    if (MEM_MemRead) begin
      if (ram_hit) begin
        MEM_ReadData = ram[ram_idx];
      end else begin
        case (word)
          TH_W:      MEM_ReadData = th;
          TL_W:      MEM_ReadData = tl;
          TCON_W:    MEM_ReadData = {29'd0, tcon};
          LED_W:     MEM_ReadData = {24'd0, led};
          SWITCH_W:  MEM_ReadData = {24'd0, switch};
          DIGI_W:    MEM_ReadData = {20'd0, digi};
          SYSTICK_W: MEM_ReadData = systick;
          default:   MEM_ReadData = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peripheral_mem.sv
// Bench for peripheral_mem: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_peripheral_mem;

  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] A_DIGI    = 32'h4000_0014;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MEM_ALUOut;
  logic [31:0] MEM_WriteData;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [7:0]  switch;
  logic [31:0] MEM_ReadData;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  peripheral_mem #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_ALUOut   (MEM_ALUOut),
    .MEM_WriteData(MEM_WriteData),
    .MEM_MemRead  (MEM_MemRead),
    .MEM_MemWrite (MEM_MemWrite),
    .switch       (switch),
    .MEM_ReadData (MEM_ReadData),
    .led          (led),
    .digi         (digi),
    .irqout       (irqout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // Behavioural model state.
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_valid [RAM_WORDS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd,
                                             output bit known);
    logic [31:0] w;
    known = 1'b1;
    w = a & ~32'h3;
    if (!rd) return 32'd0;
    if (w < RAM_BYTES) begin
      known = m_valid[int'(w >> 2)];
      return m_ram[int'(w >> 2)];
    end
    case (w)
      A_TH:      return m_th;
      A_TL:      return m_tl;
      A_TCON:    return {29'd0, m_tcon};
      A_LED:     return {24'd0, m_led};
      A_SWITCH:  return {24'd0, switch};
      A_DIGI:    return {20'd0, m_digi};
      A_SYSTICK: return m_systick;
      default:   return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [31:0] w, n_tl;
    logic [2:0]  n_tcon;
    bit          ovf;
    if (reset) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_systick = 0;
      return;
    end
    w      = MEM_ALUOut & ~32'h3;
    ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    n_tl   = m_tcon[0] ? (ovf ? m_th : m_tl + 1) : m_tl;
    n_tcon = m_tcon;
    if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
    if (MEM_MemWrite) begin
      if (w < RAM_BYTES) begin
        m_ram[int'(w >> 2)]   = MEM_WriteData;
        m_valid[int'(w >> 2)] = 1'b1;
      end
      case (w)
        A_TH:   m_th   = MEM_WriteData;
        A_TL:   n_tl   = MEM_WriteData;
        A_TCON: n_tcon = {MEM_WriteData[2] | (ovf & m_tcon[1]), MEM_WriteData[1:0]};
        A_LED:  m_led  = MEM_WriteData[7:0];
        A_DIGI: m_digi = MEM_WriteData[11:0];
        default: ;
      endcase
    end
    m_tl      = n_tl;
    m_tcon    = n_tcon;
    m_systick = m_systick + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MEM_ALUOut = a; MEM_WriteData = d; MEM_MemWrite = 1'b1; MEM_MemRead = 1'b0;
    tick();
    MEM_MemWrite = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    MEM_ALUOut = a; MEM_MemRead = 1'b1;
    #1;
    check(name, MEM_ReadData, exp);
    MEM_MemRead = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit          known;
    logic [31:0] exp;
    if (started) begin
      exp = model_read(MEM_ALUOut, MEM_MemRead, known);
      if (known) check("rdata", MEM_ReadData, exp);
      check("led", {24'd0, led}, {24'd0, m_led});
      check("digi", {20'd0, digi}, {20'd0, m_digi});
      check("irqout", {31'd0, irqout}, {31'd0, m_tcon[1] & m_tcon[2]});
    end
  end

  initial begin
    logic [31:0] a, d;
    int          sel;
    for (int i = 0; i < RAM_WORDS; i++) m_valid[i] = 1'b0;
    reset = 1'b1; MEM_ALUOut = 0; MEM_WriteData = 0;
    MEM_MemRead = 0; MEM_MemWrite = 0; switch = 8'h00;
    tick();
    started = 1'b1;
    reset   = 1'b0;

    check("rst_led", {24'd0, led}, 32'd0);
    check("rst_irq", {31'd0, irqout}, 32'd0);
    rd_check("rst_tcon", A_TCON, 32'd0);

    // RAM write/read and same-cycle read-before-write.
    wr(32'h10, 32'h1234_5678);
    rd_check("ram_rd", 32'h10, 32'h1234_5678);
    rd_check("ram_rd_lsb", 32'h13, 32'h1234_5678);
    MEM_ALUOut = 32'h10; MEM_WriteData = 32'hAAAA_5555;
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b1;
    #1;
    check("ram_rw_old", MEM_ReadData, 32'h1234_5678);
    tick();
    MEM_MemWrite = 1'b0; MEM_MemRead = 1'b0;
    rd_check("ram_rw_new", 32'h10, 32'hAAAA_5555);

    // Timer overflow and reload.
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    tick();
    rd_check("tl_ff", A_TL, 32'hFFFF_FFFF);
    tick();
    rd_check("tl_reload", A_TL, 32'hFFFF_FFF0);
    rd_check("tcon_7", A_TCON, 32'd7);
    check("irq_set", {31'd0, irqout}, 32'd1);

    // TCON write coincident with overflow keeps the status bit.
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    rd_check("tcon_keep", A_TCON, 32'd7);
    check("irq_keep", {31'd0, irqout}, 32'd1);
    wr(A_TCON, 32'd3);
    check("irq_clear", {31'd0, irqout}, 32'd0);

    // TL write beats increment.
    wr(A_TL, 32'd5);
    rd_check("tl_wr5", A_TL, 32'd5);
    tick();
    rd_check("tl_inc6", A_TL, 32'd6);

    // Switch is read-only, unmapped reads return zero, no read strobe gives zero.
    switch = 8'hA5;
    rd_check("switch", A_SWITCH, 32'h0000_00A5);
    wr(A_SWITCH, 32'h0000_0012);
    rd_check("switch_ro", A_SWITCH, 32'h0000_00A5);
    rd_check("unmapped", 32'h5000_0000, 32'd0);
    wr(A_LED, 32'h0000_00FF);
    MEM_ALUOut = A_LED; MEM_MemRead = 1'b0;
    #1;
    check("no_rd_zero", MEM_ReadData, 32'd0);
    check("led_ff", {24'd0, led}, 32'h0000_00FF);

    // Reset mid-count with a pending interrupt.
    wr(A_TL, 32'hFFFF_FFFF);
    tick();
    check("irq_pre_rst", {31'd0, irqout}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_led0", {24'd0, led}, 32'd0);
    check("rst_irq0", {31'd0, irqout}, 32'd0);
    rd_check("rst_tl0", A_TL, 32'd0);
    rd_check("rst_tcon0", A_TCON, 32'd0);
    rd_check("rst_systick0", A_SYSTICK, 32'd0);

    // Randomized traffic; the negedge process compares every cycle.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 10);
      if (sel <= 2)       a = {22'd0, 8'($urandom_range(0, RAM_WORDS - 1)), 2'b00};
      else if (sel <= 9)  a = 32'h4000_0000 + 32'(4 * (sel - 3));
      else                a = ($urandom_range(0, 1) == 1) ? 32'h4000_001C : 32'h5000_0000;
      a[1:0] = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom;
      MEM_ALUOut    = a;
      MEM_WriteData = d;
      MEM_MemRead   = ($urandom_range(0, 1) == 1);
      MEM_MemWrite  = ($urandom_range(0, 2) == 0);
      switch        = 8'($urandom);
      reset         = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; MEM_MemWrite = 1'b0; MEM_MemRead = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
